// File: rtl/fwd_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_stall_ctrl_if
// Groups the hazard flags, pipeline status and control outputs that pass
// between the pipeline datapath and the forwarding/stall control stage.
//
// Signals:
//   hazard_dx_ra/rb      F instruction reads rd of the DX instruction
//   hazard_mw_ra/rb      F instruction reads rd of the MW instruction
//   hazard_mw_dx_ra/rb   DX instruction reads rd of the MW instruction
//   dx_is_load           DX instruction is a load
//   redirect             taken branch/jump resolved in DX this cycle
//   mem_busy             data memory not ready, whole pipe holds
//   stall_f, stall_dx    hold F / DX registers
//   bubble_dx, flush_f   NOP into DX on next edge / kill fetched instruction
//   fwd_a_sel/fwd_b_sel  DX operand selects (0 regfile, 1 MW, 2 hold reg)
//   fwd_mismatch         sticky forwarding consistency error
//   stall_count          saturating count of stall_f cycles
//
// Modports: master drives the hazard/status side (datapath), slave is the
// control block.
// ---------------------------------------------------------------------------
interface fwd_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hazard_dx_ra;
    logic             hazard_dx_rb;
    logic             hazard_mw_ra;
    logic             hazard_mw_rb;
    logic             hazard_mw_dx_ra;
    logic             hazard_mw_dx_rb;
    logic             dx_is_load;
    logic             redirect;
    logic             mem_busy;
    logic             stall_f;
    logic             stall_dx;
    logic             bubble_dx;
    logic             flush_f;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             fwd_mismatch;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output hazard_dx_ra, hazard_dx_rb, hazard_mw_ra, hazard_mw_rb,
               hazard_mw_dx_ra, hazard_mw_dx_rb, dx_is_load, redirect, mem_busy,
        input  stall_f, stall_dx, bubble_dx, flush_f,
               fwd_a_sel, fwd_b_sel, fwd_mismatch, stall_count
    );

    modport slave (
        input  hazard_dx_ra, hazard_dx_rb, hazard_mw_ra, hazard_mw_rb,
               hazard_mw_dx_ra, hazard_mw_dx_rb, dx_is_load, redirect, mem_busy,
        output stall_f, stall_dx, bubble_dx, flush_f,
               fwd_a_sel, fwd_b_sel, fwd_mismatch, stall_count
    );
endinterface

// File: rtl/fwd_stall_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_stall_ctrl
// Control stage of the 3-stage (F, DX, MW) RV32I core sitting behind the
// operand hazard detector. Turns F-stage hazard flags into registered DX
// forwarding selects, generates stall/bubble/flush controls, sequences the
// load-use interlock, defers redirects that arrive during a data-memory
// wait and counts stalled fetch cycles.
//
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    fwd_stall_ctrl_if.slave (hazard flags in, controls/selects out)
//
// Parameters:
//   LOAD_USE_STALL  1 enables the load-use interlock
//   LU_CYCLES       bubbles inserted per load-use interlock (1..7)
//   CNT_W           width of the stall-cycle counter
// ---------------------------------------------------------------------------
module fwd_stall_ctrl #(
    parameter bit LOAD_USE_STALL = 1'b1,
    parameter int LU_CYCLES      = 1,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_stall_ctrl_if.slave    bus
);

    typedef enum logic {
        ST_IDLE,
        ST_LU
    } state_t;

    // Remaining interlock cycles to spend in ST_LU after the first bubble,
    // which is issued from ST_IDLE itself.
    localparam logic [2:0] LU_LOAD = 3'(LU_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_lu_cnt;
    logic [2:0]       w_lu_cnt_nxt;
    logic [2:0]       w_lu_dec;
    logic             r_redirect_pend;
    logic             w_pend_nxt;
    logic             r_dx_valid;
    logic [1:0]       r_fwd_a_sel;
    logic [1:0]       r_fwd_b_sel;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_redirect_eff;
    logic             w_lu_start;
    logic             w_adv;
    logic             w_stall_f;
    logic             w_stall_dx;
    logic             w_bubble_dx;
    logic             w_flush_f;
    logic             w_err;

    // A redirect seen during a memory wait is remembered and applied on the
    // first cycle the pipe moves again, even if the source has dropped.
    assign w_redirect_eff = (bus.redirect | r_redirect_pend) & ~bus.mem_busy;

    assign w_lu_start = LOAD_USE_STALL & bus.dx_is_load
                      & (bus.hazard_dx_ra | bus.hazard_dx_rb)
                      & ~w_redirect_eff & ~bus.mem_busy
                      & (r_state == ST_IDLE);

    assign w_adv    = ~bus.mem_busy & (r_state == ST_IDLE) & ~w_lu_start;
    assign w_lu_dec = r_lu_cnt - 3'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;
        w_pend_nxt   = r_redirect_pend;
        w_stall_f    = 1'b0;
        w_stall_dx   = 1'b0;
        w_bubble_dx  = 1'b0;
        w_flush_f    = 1'b0;

        if (bus.mem_busy) begin
            w_stall_f  = 1'b1;
            w_stall_dx = 1'b1;
            if (bus.redirect) begin
                w_pend_nxt = 1'b1;
            end
        end else if (w_redirect_eff) begin
            // Redirect wins over any interlock in progress.
            w_flush_f    = 1'b1;
            w_bubble_dx  = 1'b1;
            w_state_nxt  = ST_IDLE;
            w_lu_cnt_nxt = 3'd0;
            w_pend_nxt   = 1'b0;
        end else if (r_state == ST_LU) begin
            w_stall_f    = 1'b1;
            w_bubble_dx  = 1'b1;
            w_lu_cnt_nxt = w_lu_dec;
            // Leave on the cycle that uses up the last remaining count.
            if (w_lu_dec == 3'd0) begin
                w_state_nxt = ST_IDLE;
            end
        end else if (w_lu_start) begin
            w_stall_f   = 1'b1;
            w_bubble_dx = 1'b1;
            if (LU_CYCLES > 1) begin
                w_state_nxt  = ST_LU;
                w_lu_cnt_nxt = LU_LOAD;
            end
        end
    end

    // Combinational controls are forced low while reset is held so that a
    // memory wait on the inputs cannot leak through during reset.
    assign bus.stall_f   = rst_n & w_stall_f;
    assign bus.stall_dx  = rst_n & w_stall_dx;
    assign bus.bubble_dx = rst_n & w_bubble_dx;
    assign bus.flush_f   = rst_n & w_flush_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_lu_cnt        <= 3'd0;
            r_redirect_pend <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_lu_cnt        <= w_lu_cnt_nxt;
            r_redirect_pend <= w_pend_nxt;
        end
    end

    // A selected MW forward is only legal if the instruction now in DX
    // really reads the MW destination; bubbles are exempt.
    assign w_err = r_dx_valid
                 & (((r_fwd_a_sel == 2'd1) & ~bus.hazard_mw_dx_ra)
                  | ((r_fwd_b_sel == 2'd1) & ~bus.hazard_mw_dx_rb));

    // DX producer is younger than MW, so it takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a_sel <= 2'd0;
            r_fwd_b_sel <= 2'd0;
            r_dx_valid  <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_mismatch <= r_mismatch | w_err;
            if (bus.mem_busy) begin
                r_fwd_a_sel <= r_fwd_a_sel;
                r_fwd_b_sel <= r_fwd_b_sel;
            end else if (w_bubble_dx) begin
                r_fwd_a_sel <= 2'd0;
                r_fwd_b_sel <= 2'd0;
                r_dx_valid  <= 1'b0;
            end else if (w_adv) begin
                r_fwd_a_sel <= bus.hazard_dx_ra ? 2'd1 : (bus.hazard_mw_ra ? 2'd2 : 2'd0);
                r_fwd_b_sel <= bus.hazard_dx_rb ? 2'd1 : (bus.hazard_mw_rb ? 2'd2 : 2'd0);
                r_dx_valid  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall_f && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.fwd_a_sel    = r_fwd_a_sel;
    assign bus.fwd_b_sel    = r_fwd_b_sel;
    assign bus.fwd_mismatch = r_mismatch;
    assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_stall_ctrl
// Directed bench for fwd_stall_ctrl (LOAD_USE_STALL=1, LU_CYCLES=2, CNT_W=4).
// The driver applies one input vector per cycle just after the rising edge
// and queues the hand-computed expected outputs; a monitor pops one entry
// at every falling edge and compares against the DUT.
// Output vector layout: {stall_f, stall_dx, bubble_dx, flush_f,
//                        fwd_a_sel[1:0], fwd_b_sel[1:0], fwd_mismatch,
//                        stall_count[3:0]}
// ---------------------------------------------------------------------------
module tb_fwd_stall_ctrl;

    localparam logic [8:0] H_DXA = 9'h100;
    localparam logic [8:0] H_DXB = 9'h080;
    localparam logic [8:0] H_MWA = 9'h040;
    localparam logic [8:0] H_MWB = 9'h020;
    localparam logic [8:0] H_MDA = 9'h010;
    localparam logic [8:0] H_MDB = 9'h008;
    localparam logic [8:0] LD    = 9'h004;
    localparam logic [8:0] RD    = 9'h002;
    localparam logic [8:0] BSY   = 9'h001;
    localparam logic [8:0] NONE  = 9'h000;

    localparam logic [12:0] M_ALL  = 13'h1FFF;
    localparam logic [12:0] M_COMB = 13'h1E00;
    localparam logic [12:0] M_SEL  = 13'h01E0;
    localparam logic [12:0] M_MM   = 13'h0010;

    typedef struct {
        logic [12:0] expV;
        logic [12:0] mask;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sbQ[$];

    fwd_stall_ctrl_if #(.CNT_W(4)) bus ();

    fwd_stall_ctrl #(
        .LOAD_USE_STALL(1'b1),
        .LU_CYCLES     (2),
        .CNT_W         (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] ex(input logic sf, input logic sd, input logic bb,
                                       input logic fl, input logic [1:0] a,
                                       input logic [1:0] b, input logic mm,
                                       input logic [3:0] cnt);
        return {sf, sd, bb, fl, a, b, mm, cnt};
    endfunction

    task automatic applyStimulus(input logic [8:0] vec, input logic rstVal,
                                 input logic [12:0] expV, input logic [12:0] mask,
                                 input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n               = rstVal;
        bus.hazard_dx_ra    = vec[8];
        bus.hazard_dx_rb    = vec[7];
        bus.hazard_mw_ra    = vec[6];
        bus.hazard_mw_rb    = vec[5];
        bus.hazard_mw_dx_ra = vec[4];
        bus.hazard_mw_dx_rb = vec[3];
        bus.dx_is_load      = vec[2];
        bus.redirect        = vec[1];
        bus.mem_busy        = vec[0];
        e.expV = expV;
        e.mask = mask;
        e.name = name;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [12:0] act;
        act = {bus.stall_f, bus.stall_dx, bus.bubble_dx, bus.flush_f,
               bus.fwd_a_sel, bus.fwd_b_sel, bus.fwd_mismatch, bus.stall_count};
        checks++;
        if ((act & e.mask) !== (e.expV & e.mask)) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h mask=%h",
                     e.name, act & e.mask, e.expV & e.mask, e.mask);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int c;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.hazard_dx_ra = 1'b0; bus.hazard_dx_rb = 1'b0;
        bus.hazard_mw_ra = 1'b0; bus.hazard_mw_rb = 1'b0;
        bus.hazard_mw_dx_ra = 1'b0; bus.hazard_mw_dx_rb = 1'b0;
        bus.dx_is_load = 1'b0; bus.redirect = 1'b0; bus.mem_busy = 1'b0;
        #2 rst_n = 1'b0;

        applyStimulus(NONE, 1'b0, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "reset_state");
        @(negedge clk); #1 rst_n = 1'b1;

        // Forwarding: DX priority over MW, then hold-register forward on b
        applyStimulus(H_DXA | H_MWA | H_MDA, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "fwd_c0");
        applyStimulus(H_MDA, 1'b1, ex(0,0,0,0,2'd1,2'd0,0,4'd0), M_SEL | M_MM, "fwd_dx_prio");
        applyStimulus(H_MWB, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_SEL | M_MM, "fwd_a_clear");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd2,0,4'd0), M_SEL, "fwd_hold_b");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "fwd_b_clear");

        // Load-use interlock, two bubbles
        applyStimulus(LD | H_DXB, 1'b1, ex(1,0,1,0,2'd0,2'd0,0,4'd0), M_COMB, "lu_c0");
        applyStimulus(H_MWB, 1'b1, ex(1,0,1,0,2'd0,2'd0,0,4'd1), M_ALL, "lu_c1");
        applyStimulus(H_MWB, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd2), M_ALL, "lu_done");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd2,0,4'd2), M_ALL, "lu_fwd_b");

        // Redirect in the second interlock cycle
        applyStimulus(LD | H_DXA | H_MDA, 1'b1, ex(1,0,1,0,2'd0,2'd0,0,4'd2), M_ALL, "lu2_c0");
        applyStimulus(RD,    1'b1, ex(0,0,1,1,2'd0,2'd0,0,4'd3), M_ALL, "redir_lu");
        applyStimulus(H_DXA, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd3), M_ALL, "redir_idle");
        applyStimulus(H_DXA | H_MWB | H_MDA, 1'b1, ex(0,0,0,0,2'd1,2'd0,0,4'd3), M_ALL, "redir_fwd_a");

        // Redirect deferred across a three-cycle memory wait
        applyStimulus(RD | BSY | H_MDA, 1'b1, ex(1,1,0,0,2'd1,2'd2,0,4'd3), M_ALL, "busy_redir");
        applyStimulus(BSY | H_MDA, 1'b1, ex(1,1,0,0,2'd1,2'd2,0,4'd4), M_ALL, "busy_wait1");
        applyStimulus(BSY | H_MDA, 1'b1, ex(1,1,0,0,2'd1,2'd2,0,4'd5), M_ALL, "busy_wait2");
        applyStimulus(H_MDA, 1'b1, ex(0,0,1,1,2'd1,2'd2,0,4'd6), M_ALL, "deferred_flush");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd6), M_ALL, "flush_once");

        // Forward from MW without a matching DX read sets the sticky flag
        applyStimulus(H_DXA, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd6), M_ALL, "mm_pre0");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd1,2'd0,0,4'd6), M_ALL, "mm_pre1");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd0,1,4'd6), M_ALL, "mm_set");
        applyStimulus(NONE,  1'b1, ex(0,0,0,0,2'd0,2'd0,1,4'd6), M_ALL, "mm_sticky");

        // Long memory wait saturates the counter at 15
        for (int i = 0; i < 20; i++) begin
            c = (6 + i > 15) ? 15 : 6 + i;
            applyStimulus(BSY, 1'b1, ex(1,1,0,0,2'd0,2'd0,1,4'(c)), M_ALL, "sat");
        end

        // Reset asserted in the middle of the stall
        applyStimulus(BSY,  1'b0, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "reset_mid");
        applyStimulus(NONE, 1'b0, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "reset_hold");
        @(negedge clk); #1 rst_n = 1'b1;
        applyStimulus(NONE, 1'b1, ex(0,0,0,0,2'd0,2'd0,0,4'd0), M_ALL, "post_reset");

        for (int i = 0; i < 10 && sbQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: actual=%0d pending entries required=0", sbQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
